multi_range_tracker: RTL and testbench

//   Multi-channel successor to the single-stream range finder.

---
 rtl/multi_range_tracker.sv | 259 +++++++++++++++++++++++++
 tb/tb_multi_range_tracker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_range_tracker.sv
// multi_range_tracker
//   Per-channel min / max / sample-count tracker over a go..finish session on a
//   shared, channel-tagged sample stream.  On finish it drains one registered
//   result record per channel over a valid/ready port, channel 0 first.
//   Optional build macro SIGNED_MODE_EN: compare samples as two's complement
//   (clear values min=0111..1, max=1000..0); otherwise unsigned compare
//   (clear values min=1111..1, max=0000..0).  Ports are identical either way.
module multi_range_tracker #(
   parameter int  WIDTH     = 16,
   parameter int  CHANNELS  = 4,
   parameter int  CNT_WIDTH = 16,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 go,
   input  logic                 finish,
   input  logic                 in_valid,
   input  logic [CH_W-1:0]      in_ch,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [CH_W-1:0]      out_ch,
   output logic [WIDTH-1:0]     out_min,
   output logic [WIDTH-1:0]     out_max,
   output logic [WIDTH-1:0]     out_range,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_empty,
   output logic                 busy,
   output logic                 debug_error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]     VAL_ZERO = {WIDTH{1'b0}};
   localparam logic [CH_W-1:0]      CH_ZERO  = {CH_W{1'b0}};
   // One extra bit so the range test never degenerates for power-of-two counts.
   localparam logic [CH_W:0]        CH_LIMIT = (CH_W + 1)'(CHANNELS);
   localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(CHANNELS - 1);

`ifdef SIGNED_MODE_EN
   localparam logic [WIDTH-1:0] MIN_CLR = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_CLR = {1'b1, {(WIDTH-1){1'b0}}};
`else
   localparam logic [WIDTH-1:0] MIN_CLR = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MAX_CLR = {WIDTH{1'b0}};
`endif

   // Ordering used for both min and max tracking (a strictly below b).
   function automatic logic is_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SIGNED_MODE_EN
      return ($signed(a) < $signed(b));
`else
      return (a < b);
`endif
   endfunction

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic                   clear_s;
   logic                   apply_s;
   logic                   ch_ok_s;
   logic                   accept_s;
   logic                   last_s;

   logic [WIDTH-1:0]       min_r      [CHANNELS];
   logic [WIDTH-1:0]       max_r      [CHANNELS];
   logic [CNT_WIDTH-1:0]   cnt_r      [CHANNELS];
   logic [WIDTH-1:0]       base_min_s [CHANNELS];
   logic [WIDTH-1:0]       base_max_s [CHANNELS];
   logic [CNT_WIDTH-1:0]   base_cnt_s [CHANNELS];
   logic [CHANNELS-1:0]    hit_s;
   logic [WIDTH-1:0]       min_nxt_s  [CHANNELS];
   logic [WIDTH-1:0]       max_nxt_s  [CHANNELS];
   logic [CNT_WIDTH-1:0]   cnt_nxt_s  [CHANNELS];

   logic [CH_W-1:0]        sel_ch_r;
   logic [CH_W-1:0]        sel_ch_nxt_s;
   logic [WIDTH-1:0]       sel_min_s;
   logic [WIDTH-1:0]       sel_max_s;
   logic [CNT_WIDTH-1:0]   sel_cnt_s;
   logic                   sel_empty_s;

   logic                   out_valid_r;
   logic [WIDTH-1:0]       out_min_r;
   logic [WIDTH-1:0]       out_max_r;
   logic [WIDTH-1:0]       out_range_r;
   logic [CNT_WIDTH-1:0]   out_count_r;
   logic                   out_empty_r;
   logic                   busy_r;
   logic                   debug_error_r;

   assign ch_ok_s  = ({1'b0, in_ch} < CH_LIMIT);
   assign accept_s = (state_r == ST_DRAIN) && out_ready;
   assign last_s   = (sel_ch_r == LAST_CH);

   // Next-state logic, plus the per-edge clear / sample-apply strobes.
   always_comb begin
      state_nxt_s = state_r;
      clear_s     = 1'b0;
      apply_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (finish) begin
               state_nxt_s = ST_ERROR;
            end else if (go) begin
               state_nxt_s = ST_RUN;
               clear_s     = 1'b1;
               apply_s     = in_valid && ch_ok_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            apply_s = in_valid && ch_ok_s;
            if (in_valid && !ch_ok_s) begin
               state_nxt_s = ST_ERROR;
            end else if (go && finish) begin
               state_nxt_s = ST_ERROR;
            end else if (finish) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (accept_s && last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_ERROR: begin
            if (go && !finish) begin
               state_nxt_s = ST_RUN;
               clear_s     = 1'b1;
               apply_s     = in_valid && ch_ok_s;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Per-channel starting point for this edge: cleared values on go, else stored.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         hit_s[c]      = apply_s && (in_ch == CH_W'(c));
         base_min_s[c] = clear_s ? MIN_CLR : min_r[c];
         base_max_s[c] = clear_s ? MAX_CLR : max_r[c];
         base_cnt_s[c] = clear_s ? CNT_ZERO : cnt_r[c];
      end
   end

   // Fold the incoming sample into its channel; count saturates, min/max never stop.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         min_nxt_s[c] = (hit_s[c] && is_less(data_in, base_min_s[c])) ? data_in : base_min_s[c];
         max_nxt_s[c] = (hit_s[c] && is_less(base_max_s[c], data_in)) ? data_in : base_max_s[c];
         cnt_nxt_s[c] = (hit_s[c] && (base_cnt_s[c] != CNT_MAX)) ?
                        (base_cnt_s[c] + CNT_WIDTH'(1)) : base_cnt_s[c];
      end
   end

   // Drain pointer: 0 on entry to DRAIN, +1 per accepted record, 0 outside DRAIN.
   always_comb begin
      sel_ch_nxt_s = sel_ch_r;
      if (state_nxt_s != ST_DRAIN) begin
         sel_ch_nxt_s = CH_ZERO;
      end else if (state_r != ST_DRAIN) begin
         sel_ch_nxt_s = CH_ZERO;
      end else if (accept_s) begin
         sel_ch_nxt_s = sel_ch_r + CH_W'(1);
      end else begin
         sel_ch_nxt_s = sel_ch_r;
      end
   end

   // The record is taken from next-edge channel values so a sample arriving
   // with finish is already part of channel 0's record.
   assign sel_min_s   = min_nxt_s[sel_ch_nxt_s];
   assign sel_max_s   = max_nxt_s[sel_ch_nxt_s];
   assign sel_cnt_s   = cnt_nxt_s[sel_ch_nxt_s];
   assign sel_empty_s = (sel_cnt_s == CNT_ZERO);

   // State, drain pointer and per-channel statistics registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         sel_ch_r <= CH_ZERO;
         for (int c = 0; c < CHANNELS; c++) begin
            min_r[c] <= MIN_CLR;
            max_r[c] <= MAX_CLR;
            cnt_r[c] <= CNT_ZERO;
         end
      end else begin
         state_r  <= state_nxt_s;
         sel_ch_r <= sel_ch_nxt_s;
         for (int c = 0; c < CHANNELS; c++) begin
            min_r[c] <= min_nxt_s[c];
            max_r[c] <= max_nxt_s[c];
            cnt_r[c] <= cnt_nxt_s[c];
         end
      end
   end

   // Registered result record and status flags, all zero outside their states.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_r   <= 1'b0;
         out_min_r     <= VAL_ZERO;
         out_max_r     <= VAL_ZERO;
         out_range_r   <= VAL_ZERO;
         out_count_r   <= CNT_ZERO;
         out_empty_r   <= 1'b0;
         busy_r        <= 1'b0;
         debug_error_r <= 1'b0;
      end else begin
         busy_r        <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
         debug_error_r <= (state_nxt_s == ST_ERROR);
         if (state_nxt_s == ST_DRAIN) begin
            out_valid_r <= 1'b1;
            out_min_r   <= sel_empty_s ? VAL_ZERO : sel_min_s;
            out_max_r   <= sel_empty_s ? VAL_ZERO : sel_max_s;
            out_range_r <= sel_empty_s ? VAL_ZERO : (sel_max_s - sel_min_s);
            out_count_r <= sel_cnt_s;
            out_empty_r <= sel_empty_s;
         end else begin
            out_valid_r <= 1'b0;
            out_min_r   <= VAL_ZERO;
            out_max_r   <= VAL_ZERO;
            out_range_r <= VAL_ZERO;
            out_count_r <= CNT_ZERO;
            out_empty_r <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign out_ch      = sel_ch_r;
   assign out_min     = out_min_r;
   assign out_max     = out_max_r;
   assign out_range   = out_range_r;
   assign out_count   = out_count_r;
   assign out_empty   = out_empty_r;
   assign busy        = busy_r;
   assign debug_error = debug_error_r;

endmodule

// File: tb/tb_multi_range_tracker.sv
// tb_multi_range_tracker
//   Directed bench for multi_range_tracker.  Instance A: W=16, CH=4, CNT=16.
//   Instance B: W=8, CH=5, CNT=3 (counter saturation, 8-bit compare mode,
//   out-of-range channel tag).  Expected records are hand-computed.
module tb_multi_range_tracker;

   logic clock = 1'b0;
   logic reset;

   logic        a_go, a_finish, a_in_valid, a_out_ready;
   logic [1:0]  a_in_ch;
   logic [15:0] a_data_in;
   logic        a_out_valid, a_out_empty, a_busy, a_debug_error;
   logic [1:0]  a_out_ch;
   logic [15:0] a_out_min, a_out_max, a_out_range, a_out_count;

   logic        b_go, b_finish, b_in_valid, b_out_ready;
   logic [2:0]  b_in_ch;
   logic [7:0]  b_data_in;
   logic        b_out_valid, b_out_empty, b_busy, b_debug_error;
   logic [2:0]  b_out_ch;
   logic [7:0]  b_out_min, b_out_max, b_out_range;
   logic [2:0]  b_out_count;

   int n_pass  = 0;
   int n_total = 0;

   multi_range_tracker #(.WIDTH(16), .CHANNELS(4), .CNT_WIDTH(16)) dut_a (
      .clock(clock), .reset(reset), .go(a_go), .finish(a_finish),
      .in_valid(a_in_valid), .in_ch(a_in_ch), .data_in(a_data_in),
      .out_ready(a_out_ready), .out_valid(a_out_valid), .out_ch(a_out_ch),
      .out_min(a_out_min), .out_max(a_out_max), .out_range(a_out_range),
      .out_count(a_out_count), .out_empty(a_out_empty), .busy(a_busy),
      .debug_error(a_debug_error)
   );

   multi_range_tracker #(.WIDTH(8), .CHANNELS(5), .CNT_WIDTH(3)) dut_b (
      .clock(clock), .reset(reset), .go(b_go), .finish(b_finish),
      .in_valid(b_in_valid), .in_ch(b_in_ch), .data_in(b_data_in),
      .out_ready(b_out_ready), .out_valid(b_out_valid), .out_ch(b_out_ch),
      .out_min(b_out_min), .out_max(b_out_max), .out_range(b_out_range),
      .out_count(b_out_count), .out_empty(b_out_empty), .busy(b_busy),
      .debug_error(b_debug_error)
   );

   always #5 clock = ~clock;

   // Packed view of the current record: {valid, ch, min, max, range, count, empty}.
   function automatic logic [67:0] a_rec();
      return {a_out_valid, a_out_ch, a_out_min, a_out_max, a_out_range, a_out_count, a_out_empty};
   endfunction

   function automatic logic [31:0] b_rec();
      return {b_out_valid, b_out_ch, b_out_min, b_out_max, b_out_range, b_out_count, b_out_empty};
   endfunction

   task automatic drive_a(input logic g, input logic f, input logic v,
                          input logic [1:0] ch, input logic [15:0] d);
      a_go = g; a_finish = f; a_in_valid = v; a_in_ch = ch; a_data_in = d;
      @(posedge clock); #1;
      a_go = 1'b0; a_finish = 1'b0; a_in_valid = 1'b0; a_in_ch = 2'd0; a_data_in = 16'd0;
   endtask

   task automatic drive_b(input logic g, input logic f, input logic v,
                          input logic [2:0] ch, input logic [7:0] d);
      b_go = g; b_finish = f; b_in_valid = v; b_in_ch = ch; b_data_in = d;
      @(posedge clock); #1;
      b_go = 1'b0; b_finish = 1'b0; b_in_valid = 1'b0; b_in_ch = 3'd0; b_data_in = 8'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_go = 1'b0; a_finish = 1'b0; a_in_valid = 1'b0; a_in_ch = 2'd0; a_data_in = 16'd0; a_out_ready = 1'b0;
      b_go = 1'b0; b_finish = 1'b0; b_in_valid = 1'b0; b_in_ch = 3'd0; b_data_in = 8'd0; b_out_ready = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      n_total++;
      if ({a_rec(), a_busy, a_debug_error} !== 70'd0)
         $display("FAIL reset_a: got %h want 0", {a_rec(), a_busy, a_debug_error});
      else n_pass++;
      n_total++;
      if ({b_rec(), b_busy, b_debug_error} !== 34'd0)
         $display("FAIL reset_b: got %h want 0", {b_rec(), b_busy, b_debug_error});
      else n_pass++;
      reset = 1'b0;
      drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_busy, a_debug_error, a_out_valid} !== 3'b000)
         $display("FAIL reset_idle: got %b want 000", {a_busy, a_debug_error, a_out_valid});
      else n_pass++;
   endtask

   task automatic test_basic();
      int e_min [4] = '{2, 0, 100, 0};
      int e_max [4] = '{9, 0, 100, 0};
      int e_rng [4] = '{7, 0, 0, 0};
      int e_cnt [4] = '{3, 0, 1, 0};
      bit e_emp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [67:0] exp_v;
      a_out_ready = 1'b0;
      drive_a(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_busy, a_debug_error, a_out_valid} !== 3'b100)
         $display("FAIL basic_run: got %b want 100", {a_busy, a_debug_error, a_out_valid});
      else n_pass++;
      drive_a(1'b0, 1'b0, 1'b1, 2'd0, 16'd5);
      drive_a(1'b0, 1'b0, 1'b1, 2'd0, 16'd9);
      drive_a(1'b0, 1'b0, 1'b1, 2'd0, 16'd2);
      drive_a(1'b0, 1'b0, 1'b1, 2'd2, 16'd100);
      n_total++;
      if (a_out_valid !== 1'b0)
         $display("FAIL basic_novalid_run: got %b want 0", a_out_valid);
      else n_pass++;
      drive_a(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      // stall: ch0 record held while out_ready is low
      for (int i = 0; i < 5; i++) begin
         exp_v = {1'b1, 2'd0, 16'd2, 16'd9, 16'd7, 16'd3, 1'b0};
         n_total++;
         if (a_rec() !== exp_v)
            $display("FAIL stall_hold[%0d]: got %h want %h", i, a_rec(), exp_v);
         else n_pass++;
         drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      end
      a_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_v = {1'b1, 2'(k), 16'(e_min[k]), 16'(e_max[k]), 16'(e_rng[k]), 16'(e_cnt[k]), e_emp[k]};
         n_total++;
         if (a_rec() !== exp_v)
            $display("FAIL basic_rec[%0d]: got %h want %h", k, a_rec(), exp_v);
         else n_pass++;
         drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      end
      n_total++;
      if ({a_out_valid, a_busy} !== 2'b00)
         $display("FAIL basic_idle_after: got %b want 00", {a_out_valid, a_busy});
      else n_pass++;
      a_out_ready = 1'b0;
   endtask

   task automatic test_edge_samples();
      logic [67:0] exp_v [4];
      exp_v[0] = {1'b1, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1};
      exp_v[1] = {1'b1, 2'd1, 16'd40, 16'd50, 16'd10, 16'd2, 1'b0};
      exp_v[2] = {1'b1, 2'd2, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1};
      exp_v[3] = {1'b1, 2'd3, 16'd7, 16'd7, 16'd0, 16'd1, 1'b0};
      // sample on the go cycle lands after the clear
      drive_a(1'b1, 1'b0, 1'b1, 2'd3, 16'd7);
      drive_a(1'b0, 1'b0, 1'b1, 2'd1, 16'd50);
      a_out_ready = 1'b1;
      // sample on the finish cycle is part of the session
      drive_a(1'b0, 1'b1, 1'b1, 2'd1, 16'd40);
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (a_rec() !== exp_v[k])
            $display("FAIL edge_rec[%0d]: got %h want %h", k, a_rec(), exp_v[k]);
         else n_pass++;
         // go and samples during DRAIN must be ignored
         drive_a(1'b1, 1'b0, 1'b1, 2'd3, 16'd999);
      end
      n_total++;
      if ({a_out_valid, a_busy, a_debug_error} !== 3'b000)
         $display("FAIL edge_idle_after: got %b want 000", {a_out_valid, a_busy, a_debug_error});
      else n_pass++;
      a_out_ready = 1'b0;
   endtask

   task automatic test_error();
      drive_a(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_debug_error, a_busy, a_out_valid} !== 3'b100)
         $display("FAIL err_finish_idle: got %b want 100", {a_debug_error, a_busy, a_out_valid});
      else n_pass++;
      drive_a(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_debug_error, a_busy} !== 2'b01)
         $display("FAIL err_go_recover: got %b want 01", {a_debug_error, a_busy});
      else n_pass++;
      drive_a(1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_debug_error, a_busy, a_out_valid} !== 3'b100)
         $display("FAIL err_go_finish_run: got %b want 100", {a_debug_error, a_busy, a_out_valid});
      else n_pass++;
      drive_a(1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_debug_error, a_busy} !== 2'b10)
         $display("FAIL err_stay: got %b want 10", {a_debug_error, a_busy});
      else n_pass++;
      drive_a(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      drive_a(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_out_valid, a_out_ch, a_out_empty, a_out_count} !== {1'b1, 2'd0, 1'b1, 16'd0})
         $display("FAIL err_empty_drain: got %h want %h", {a_out_valid, a_out_ch, a_out_empty, a_out_count},
                  {1'b1, 2'd0, 1'b1, 16'd0});
      else n_pass++;
      a_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      a_out_ready = 1'b0;
      // go together with finish in IDLE also errors
      drive_a(1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_debug_error, a_busy} !== 2'b10)
         $display("FAIL err_go_finish_idle: got %b want 10", {a_debug_error, a_busy});
      else n_pass++;
   endtask

   task automatic test_saturation();
      int sv [10] = '{10, 3, 7, 20, 15, 4, 9, 1, 30, 12};
      logic [31:0] exp_v;
      b_out_ready = 1'b1;
      drive_b(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 10; i++) drive_b(1'b0, 1'b0, 1'b1, 3'd1, 8'(sv[i]));
      drive_b(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
      exp_v = {1'b1, 3'd0, 8'd0, 8'd0, 8'd0, 3'd0, 1'b1};
      n_total++;
      if (b_rec() !== exp_v) $display("FAIL sat_ch0: got %h want %h", b_rec(), exp_v);
      else n_pass++;
      drive_b(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      exp_v = {1'b1, 3'd1, 8'd1, 8'd30, 8'd29, 3'd7, 1'b0};
      n_total++;
      if (b_rec() !== exp_v) $display("FAIL sat_ch1: got %h want %h", b_rec(), exp_v);
      else n_pass++;
      for (int k = 0; k < 4; k++) drive_b(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      n_total++;
      if ({b_out_valid, b_busy} !== 2'b00)
         $display("FAIL sat_idle_after: got %b want 00", {b_out_valid, b_busy});
      else n_pass++;
   endtask

   task automatic test_signed();
      logic [31:0] exp_v;
`ifdef SIGNED_MODE_EN
      exp_v = {1'b1, 3'd0, 8'h80, 8'h7F, 8'hFF, 3'd2, 1'b0};
`else
      exp_v = {1'b1, 3'd0, 8'h7F, 8'h80, 8'h01, 3'd2, 1'b0};
`endif
      b_out_ready = 1'b1;
      drive_b(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      drive_b(1'b0, 1'b0, 1'b1, 3'd0, 8'h80);
      drive_b(1'b0, 1'b0, 1'b1, 3'd0, 8'h7F);
      drive_b(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
      n_total++;
      if (b_rec() !== exp_v) $display("FAIL compare_mode: got %h want %h", b_rec(), exp_v);
      else n_pass++;
      for (int k = 0; k < 5; k++) drive_b(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      n_total++;
      if ({b_out_valid, b_busy} !== 2'b00)
         $display("FAIL compare_idle_after: got %b want 00", {b_out_valid, b_busy});
      else n_pass++;
   endtask

   task automatic test_bad_channel();
      drive_b(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      drive_b(1'b0, 1'b0, 1'b1, 3'd2, 8'd33);
      n_total++;
      if ({b_busy, b_debug_error} !== 2'b10)
         $display("FAIL badch_good_sample: got %b want 10", {b_busy, b_debug_error});
      else n_pass++;
      drive_b(1'b0, 1'b0, 1'b1, 3'd5, 8'd0);
      n_total++;
      if ({b_busy, b_debug_error, b_out_valid} !== 3'b010)
         $display("FAIL badch_error: got %b want 010", {b_busy, b_debug_error, b_out_valid});
      else n_pass++;
      drive_b(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
      n_total++;
      if ({b_busy, b_debug_error, b_out_valid} !== 3'b010)
         $display("FAIL badch_finish_in_error: got %b want 010", {b_busy, b_debug_error, b_out_valid});
      else n_pass++;
   endtask

   task automatic test_reset_drain();
      a_out_ready = 1'b0;
      drive_a(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      drive_a(1'b0, 1'b0, 1'b1, 2'd1, 16'd11);
      drive_a(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_out_valid, a_out_ch} !== 3'b100)
         $display("FAIL rstd_in_drain: got %b want 100", {a_out_valid, a_out_ch});
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_total++;
      if ({a_rec(), a_busy, a_debug_error} !== 70'd0)
         $display("FAIL rstd_async_zero: got %h want 0", {a_rec(), a_busy, a_debug_error});
      else n_pass++;
      @(posedge clock); #1;
      reset = 1'b0;
      drive_a(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      drive_a(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      a_out_ready = 1'b1;
      drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      n_total++;
      if (a_rec() !== {1'b1, 2'd1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1})
         $display("FAIL rstd_ch1_cleared: got %h want %h", a_rec(), {1'b1, 2'd1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1});
      else n_pass++;
      for (int k = 0; k < 3; k++) drive_a(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      n_total++;
      if ({a_out_valid, a_busy} !== 2'b00)
         $display("FAIL rstd_idle_after: got %b want 00", {a_out_valid, a_busy});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edge_samples();
      test_error();
      test_saturation();
      test_signed();
      test_bad_channel();
      test_reset_drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
